// File: rtl/lbp_hist_riu2.sv
// Rotation-invariant uniform (riu2) LBP histogram: bins codes over a frame, then streams 10 bins out.
// Define LBP_HIST_SAT_EN to make bin counters saturate instead of wrapping.
module lbp_hist_riu2 #(
  parameter int NBINS = 10,
  parameter int CNT_W = 14
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             lbp_valid,
  input  logic [13:0]      lbp_addr,
  input  logic [7:0]       lbp_data,
  input  logic             finish,
  output logic             hist_valid,
  input  logic             hist_ready,
  output logic [3:0]       hist_bin,
  output logic [CNT_W-1:0] hist_count,
  output logic             hist_done
);

  typedef enum logic [1:0] {ACC, FLUSH, DUMP, DONE} state_t;

  state_t           state, state_next;
  logic             flush_cnt;
  logic             vld_p0;
  logic [3:0]       bin_p0;
  logic [13:0]      addr_unused_p0;
  logic [CNT_W-1:0] cnt [NBINS];
  logic             load_first, advance, dump_end;
  logic [3:0]       sel_bin;
  logic [CNT_W-1:0] sel_count;

  function automatic logic [3:0] popcount8(input logic [7:0] d);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, d[i]};
    return n;
  endfunction

  // Uniform codes have at most two 0/1 transitions around the circle.
  function automatic logic [3:0] riu2_bin(input logic [7:0] d);
    logic [7:0] rot;
    rot = {d[0], d[7:1]};
    if (popcount8(d ^ rot) <= 4'd2) return popcount8(d);
    else return 4'(NBINS - 1);
  endfunction

  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
`ifdef LBP_HIST_SAT_EN
    return (&c) ? c : c + CNT_W'(1);
`else
    return c + CNT_W'(1);
`endif
  endfunction

  // Stage p0: classify and register the bin
  always_ff @(posedge clk) begin
    if (reset) vld_p0 <= 1'b0;
    else       vld_p0 <= lbp_valid && (state == ACC);
  end

  always_ff @(posedge clk) begin
    bin_p0         <= riu2_bin(lbp_data);
    addr_unused_p0 <= lbp_addr;
  end

  // Stage p1: the only place counters are written, so back-to-back hits need no forwarding
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NBINS; i++) cnt[i] <= '0;
    end else if (vld_p0) begin
      for (int i = 0; i < NBINS; i++)
        if (bin_p0 == 4'(i)) cnt[i] <= cnt_inc(cnt[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ACC;
      flush_cnt <= 1'b0;
    end else begin
      state     <= state_next;
      flush_cnt <= (state == FLUSH) ? ~flush_cnt : 1'b0;
    end
  end

  always_comb begin
    state_next = state;
    load_first = 1'b0;
    advance    = 1'b0;
    dump_end   = 1'b0;
    unique case (state)
      ACC:   if (finish) state_next = FLUSH;
      FLUSH: if (flush_cnt) begin
               state_next = DUMP;
               load_first = 1'b1;
             end
      DUMP:  if (hist_valid && hist_ready) begin
               if (hist_bin == 4'(NBINS - 1)) begin
                 state_next = DONE;
                 dump_end   = 1'b1;
               end else begin
                 advance = 1'b1;
               end
             end
      DONE:  state_next = DONE;
      default: state_next = ACC;
    endcase
  end

  always_comb begin
    sel_bin   = load_first ? 4'd0 : hist_bin + 4'd1;
    sel_count = '0;
    for (int i = 0; i < NBINS; i++)
      if (sel_bin == 4'(i)) sel_count = cnt[i];
  end

  // Output register: holds steady while the sink stalls
  always_ff @(posedge clk) begin
    if (reset) begin
      hist_valid <= 1'b0;
      hist_bin   <= '0;
      hist_count <= '0;
      hist_done  <= 1'b0;
    end else if (load_first || advance) begin
      hist_valid <= 1'b1;
      hist_bin   <= sel_bin;
      hist_count <= sel_count;
    end else if (dump_end) begin
      hist_valid <= 1'b0;
      hist_done  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_lbp_hist_riu2.sv
// Bench for lbp_hist_riu2: random frames checked against a bit-loop riu2 histogram model.
module tb_lbp_hist_riu2;
  localparam int NBINS = 10;
  localparam int CNT_W = 14;

  logic clk = 1'b0, reset = 1'b1, lbp_valid = 1'b0, finish = 1'b0, hist_ready = 1'b0;
  logic [13:0] lbp_addr = '0;
  logic [7:0]  lbp_data = '0;
  logic hist_valid, hist_done, hist_valid4, hist_done4;
  logic [3:0] hist_bin, hist_bin4, hist_count4;
  logic [CNT_W-1:0] hist_count;

  int checks = 0, errors = 0;
  int exp_hist [NBINS];
  int exp_idx = 0;
  bit exp_done = 1'b0, reset_d = 1'b0;

  always #5 clk = ~clk;

  lbp_hist_riu2 #(.NBINS(NBINS), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .lbp_valid(lbp_valid), .lbp_addr(lbp_addr), .lbp_data(lbp_data),
    .finish(finish), .hist_valid(hist_valid), .hist_ready(hist_ready), .hist_bin(hist_bin),
    .hist_count(hist_count), .hist_done(hist_done));

  lbp_hist_riu2 #(.NBINS(NBINS), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .lbp_valid(lbp_valid), .lbp_addr(lbp_addr), .lbp_data(lbp_data),
    .finish(finish), .hist_valid(hist_valid4), .hist_ready(hist_ready), .hist_bin(hist_bin4),
    .hist_count(hist_count4), .hist_done(hist_done4));

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Count circular bit changes directly; uniform means at most two.
  function automatic int riu2_bin(input logic [7:0] d);
    int trans = 0, ones = 0;
    for (int i = 0; i < 8; i++) begin
      if (d[i]) ones++;
      if (d[i] != d[(i + 1) % 8]) trans++;
    end
    return (trans <= 2) ? ones : 9;
  endfunction

  function automatic int exp_cnt14(input int x);
    return x % 16384;
  endfunction

  function automatic int exp_cnt4(input int x);
`ifdef LBP_HIST_SAT_EN
    return (x > 15) ? 15 : x;
`else
    return x % 16;
`endif
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      if (reset_d) begin
        chk("rst_valid", int'(hist_valid), 0);
        chk("rst_done", int'(hist_done), 0);
        chk("rst_bin", int'(hist_bin), 0);
        chk("rst_count", int'(hist_count), 0);
      end
      exp_idx  = 0;
      exp_done = 1'b0;
    end else begin
      chk("done", int'(hist_done), int'(exp_done));
      chk("done4", int'(hist_done4), int'(exp_done));
      if (hist_valid) begin
        if (exp_idx >= NBINS) begin
          chk("bin_after_last", int'(hist_bin), NBINS - 1 - exp_idx);
        end else begin
          chk("bin", int'(hist_bin), exp_idx);
          chk("count", int'(hist_count), exp_cnt14(exp_hist[exp_idx]));
          chk("valid4", int'(hist_valid4), 1);
          chk("bin4", int'(hist_bin4), exp_idx);
          chk("count4", int'(hist_count4), exp_cnt4(exp_hist[exp_idx]));
          if (hist_ready) begin
            if (exp_idx == NBINS - 1) exp_done = 1'b1;
            exp_idx++;
          end
        end
      end
    end
    reset_d = reset;
  end

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1; lbp_valid = 1'b0; finish = 1'b0; hist_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < NBINS; i++) exp_hist[i] = 0;
  endtask

  task automatic send(input logic [7:0] d, input int gap);
    @(posedge clk); #1;
    lbp_valid = 1'b1; lbp_data = d; lbp_addr = lbp_addr + 14'd1;
    exp_hist[riu2_bin(d)]++;
    repeat (gap) begin
      @(posedge clk); #1;
      lbp_valid = 1'b0; lbp_data = 8'($urandom);
    end
  endtask

  // Raise finish (optionally with a final code), junk-pulse lbp_valid during FLUSH, check dump latency.
  task automatic end_frame(input bit with_code, input logic [7:0] d);
    int n = 0;
    @(posedge clk); #1;
    finish = 1'b1; lbp_valid = with_code; lbp_data = d;
    if (with_code) exp_hist[riu2_bin(d)]++;
    do begin
      @(negedge clk); n++;
      if (n >= 2) begin
        lbp_valid = 1'($urandom_range(0, 1)); lbp_data = 8'($urandom);
      end
    end while (!hist_valid && n < 50);
    chk("dump_latency", n, 4);
    finish = 1'b0; lbp_valid = 1'b0;
  endtask

  // mode 0: ready=1; 1: random ready; 2: stall 5 cycles at bin 3 with junk codes; 3: reset at bin 5
  task automatic dump(input int mode);
    int n = 0, stall = 0;
    bit hit = 1'b0;
    while (!hist_done && n < 300 && !hit) begin
      @(posedge clk); #1; n++;
      case (mode)
        0: hist_ready = 1'b1;
        1: hist_ready = 1'($urandom_range(0, 1));
        2: begin
             hist_ready = 1'b1;
             if (hist_valid && hist_bin == 4'd3 && stall < 5) begin
               hist_ready = 1'b0; stall++;
             end
             lbp_valid = 1'($urandom_range(0, 1)); lbp_data = 8'h00;
           end
        default: begin
             hist_ready = 1'($urandom_range(0, 1));
             if (hist_valid && hist_bin == 4'd5) begin
               reset = 1'b1; hist_ready = 1'b0; hit = 1'b1;
             end
           end
      endcase
    end
    lbp_valid = 1'b0;
    if (mode == 3) begin
      chk("reached_bin5", int'(hit), 1);
    end else begin
      chk("dump_done", int'(hist_done), 1);
      chk("bins_delivered", exp_idx, NBINS);
      if (mode == 2) chk("stall_cycles", stall, 5);
    end
    hist_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] codes [6];
    int pin_b [NBINS];
    codes = '{8'hFF, 8'h0F, 8'h81, 8'h55, 8'h01, 8'h03};
    pin_b = '{0, 1, 2, 0, 1, 0, 0, 0, 1, 1};

    do_reset();
    chk("post_rst_valid", int'(hist_valid), 0);
    chk("post_rst_done", int'(hist_done), 0);
    chk("post_rst_count", int'(hist_count), 0);

    repeat (100) send(8'h00, 0);
    end_frame(1'b0, 8'h00);
    chk("model_bin0_100", exp_hist[0], 100);
    dump(0);

    do_reset();
    foreach (codes[i]) send(codes[i], 2);
    end_frame(1'b0, 8'h00);
    for (int b = 0; b < NBINS; b++) chk("model_pin_mixed", exp_hist[b], pin_b[b]);
    dump(1);

    do_reset();
    repeat (150) send(8'($urandom), $urandom_range(0, 2));
    end_frame(1'b1, 8'h00);
    dump(2);

    do_reset();
    repeat (40) send(8'($urandom), 0);
    end_frame(1'b0, 8'h00);
    dump(3);
    do_reset();
    repeat (3) send(8'hFF, 0);
    end_frame(1'b0, 8'h00);
    chk("model_bin8_3", exp_hist[8], 3);
    dump(0);

    do_reset();
    repeat (20) send(8'hFF, 0);
    end_frame(1'b0, 8'h00);
`ifdef LBP_HIST_SAT_EN
    chk("model_cnt4_pin", exp_cnt4(exp_hist[8]), 15);
`else
    chk("model_cnt4_pin", exp_cnt4(exp_hist[8]), 4);
`endif
    dump(1);

    for (int f = 0; f < 3; f++) begin
      do_reset();
      repeat ($urandom_range(50, 300)) send(8'($urandom), $urandom_range(0, 1));
      end_frame(1'($urandom_range(0, 1)), 8'($urandom));
      dump(1);
    end
    do_reset();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
